dev_bus_arb: RTL and testbench
==============================

DEV_BUS_ARB -- requirements
Module: dev_bus_arb

Parameters
REQ-001 The block SHALL provide parameter PRIO_FIXED, default 0: 0 = round-robin arbitration, 1 = master 0 has fixed priority.
REQ-002 The block SHALL provide parameter STARVE_LIMIT, default 8: consecutive lost arbitrations after which master 1 wins in fixed-priority mode; legal range 1..15.

Interface
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m0_req, m1_req  in  1 each  transaction request; held high until the master's done pulse.
REQ-006 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  in  32 each  byte address.
REQ-008 m0_wd, m1_wd  in  32 each  write data.
REQ-009 m0_gnt, m1_gnt  out  1 each  ownership indicator; at most one high.
REQ-010 m0_done, m1_done  out  1 each  one-cycle completion pulse.
REQ-011 m0_rdata, m1_rdata  out  32 each  read data; valid while the matching done is high.
REQ-012 bus_addr  out  32  device bus address, fed to the bridge PrAddr input.
REQ-013 bus_wd  out  32  device bus write data, fed to the bridge PrWD input.
REQ-014 bus_we  out  1  device bus write enable, fed to the bridge MemWrM input.
REQ-015 bus_rd  in  32  device bus read data, from the bridge PrRD output.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-018 IDLE SHALL move to ACCESS on the next edge if either req is high; otherwise it SHALL stay in IDLE.
REQ-019 ACCESS SHALL always move to RESP, and RESP SHALL always move to IDLE; a transaction therefore lasts 3 cycles, req-sample to done inclusive.
REQ-020 On the IDLE->ACCESS edge, the arbiter SHALL latch the winner's id, we, addr and wd into internal registers.
REQ-021 During ACCESS, bus_addr, bus_wd and bus_we SHALL be driven from the latched registers.
REQ-022 bus_we SHALL be 0 in all states other than ACCESS, and bus_addr and bus_wd SHALL be 0 in all states other than ACCESS.
REQ-023 On the ACCESS->RESP edge, bus_rd SHALL be captured into the winner's rdata register; for writes the captured value is don't-care.
REQ-024 During RESP, the winner's done SHALL be high for exactly one cycle.
REQ-025 The winner's gnt SHALL be high during ACCESS and RESP only.
REQ-026 Once latched, a transaction SHALL complete using the latched values even if req drops, addr changes or reset is not asserted; no partial abort is permitted.
REQ-027 A req still high in the IDLE cycle after done SHALL be treated as a new transaction.
REQ-028 Round-robin mode: when only one req is high, that master SHALL win.
REQ-029 Round-robin mode: when both reqs are high, the master that is not last_winner SHALL win.
REQ-030 Round-robin mode: last_winner SHALL update on every grant.
REQ-031 Fixed mode: master 0 SHALL win ties, except that master 1 SHALL win when starve_cnt equals STARVE_LIMIT.
REQ-032 starve_cnt (4 bits) SHALL increment at each IDLE arbitration where m1_req is high and master 0 wins.
REQ-033 starve_cnt SHALL clear to 0 when master 1 is granted and SHALL saturate at STARVE_LIMIT.
REQ-034 In round-robin mode, starve_cnt SHALL remain 0.
REQ-035 rdata registers SHALL hold their value until that master's next read capture.

Reset
REQ-036 Reset SHALL asynchronously force state IDLE, last_winner = 1 (so master 0 wins the first tie) and starve_cnt = 0.
REQ-037 Reset SHALL force all gnt, done, bus_we, bus_addr, bus_wd, busy and rdata outputs and registers to 0.
REQ-038 Reset asserted during ACCESS or RESP SHALL abandon the transaction with no done pulse; any write performed during an already-completed ACCESS cycle is not undone.
REQ-039 After reset deassertion, the first arbitration SHALL occur at the first rising edge in IDLE with a req high.

Verification
REQ-040 Single read: m0 reads 0x00007f04 while bus_rd = 0xCAFE0001 -> ACCESS at cycle 1 with bus_addr = 0x00007f04 and bus_we = 0; m0_done = 1 with m0_rdata = 0xCAFE0001 at cycle 2; IDLE at cycle 3.
REQ-041 Round-robin tie: both reqs held high continuously for 4 transactions -> grant order m0, m1, m0, m1, with done pulses at cycles 2, 5, 8 and 11.
REQ-042 Fixed mode, STARVE_LIMIT = 2, both reqs held high -> grant order m0, m0, m1, m0, m0, m1.
REQ-043 Write: m1 writes 0x12 to 0x00007f10 -> bus_we = 1 for exactly one cycle with bus_wd = 0x00000012; m1_done pulses one cycle later; bus_we = 0 elsewhere.
REQ-044 Reset mid-ACCESS: reset asserted asynchronously during an m0 read -> all outputs 0 immediately, no m0_done pulse; after release, a pending m0_req starts a fresh 3-cycle transaction.
REQ-045 Req drop: m0_req deasserted during ACCESS -> m0_done still pulses in RESP, and no new transaction starts.

Source files
------------

// File: rtl/dev_bus_arb_if.sv
// dev_bus_arb_if
//   Bundles the two master request channels, the per-master grant/done/read
//   data returns and the device-bus side (address, write data, write enable,
//   read data) of the two-master device bus arbiter.
//   slave  : arbiter view (requests and bus_rd in; grants, done, rdata, bus_* and busy out)
//   master : view of whatever drives the requests and observes the results
interface dev_bus_arb_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_we;
  logic        m1_we;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wd;
  logic [31:0] m1_wd;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_done;
  logic        m1_done;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wd;
  logic        bus_we;
  logic [31:0] bus_rd;
  logic        busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, bus_rd,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           bus_addr, bus_wd, bus_we, busy
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, bus_rd,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           bus_addr, bus_wd, bus_we, busy
  );
endinterface

// File: rtl/dev_bus_arb.sv
// dev_bus_arb
//   Two-master arbiter in front of a single device bus bridge. Every
//   transaction takes exactly three cycles: IDLE (request sampled), ACCESS
//   (bus driven), RESP (done pulse, read data valid).
//   Arbitration is round-robin (PRIO_FIXED = 0) or master-0 priority with a
//   starvation escape for master 1 after STARVE_LIMIT lost ties (PRIO_FIXED = 1).
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   arb   : dev_bus_arb_if.slave -- master channels and device bus
module dev_bus_arb #(
  parameter int PRIO_FIXED   = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  dev_bus_arb_if.slave   arb
);

  localparam bit         FIXED = (PRIO_FIXED != 0);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;      // id of the most recent winner
  logic [3:0]  starve_q, starve_d;
  logic        win_q, win_d;        // id of the transaction in flight
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  // The bus registers double as the latched transaction: they are loaded
  // on the grant edge and cleared when ACCESS ends, so the bus reads zero
  // outside ACCESS without any output gating.
  logic [31:0] bus_addr_q, bus_addr_d, bus_wd_q, bus_wd_d;
  logic        bus_we_q, bus_we_d;
  logic        busy_q, busy_d;

  logic        pick;

  always_comb begin
    if (arb.m0_req && arb.m1_req) begin
      pick = FIXED ? (starve_q == LIMIT) : ~last_q;
    end else begin
      pick = arb.m1_req;
    end

    state_d    = state_q;
    last_d     = last_q;
    starve_d   = starve_q;
    win_d      = win_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    bus_addr_d = bus_addr_q;
    bus_wd_d   = bus_wd_q;
    bus_we_d   = bus_we_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (arb.m0_req || arb.m1_req) begin
          state_d    = ACCESS;
          win_d      = pick;
          last_d     = pick;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          busy_d     = 1'b1;
          bus_addr_d = pick ? arb.m1_addr : arb.m0_addr;
          bus_wd_d   = pick ? arb.m1_wd   : arb.m0_wd;
          bus_we_d   = pick ? arb.m1_we   : arb.m0_we;
          if (FIXED) begin
            if (pick) begin
              starve_d = 4'd0;
            end else if (arb.m1_req && starve_q != LIMIT) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      ACCESS: begin
        state_d    = RESP;
        bus_addr_d = 32'd0;
        bus_wd_d   = 32'd0;
        bus_we_d   = 1'b0;
        // Only reads capture, so a master's rdata survives its writes.
        if (!bus_we_q) begin
          if (win_q) rdata1_d = arb.bus_rd;
          else       rdata0_d = arb.bus_rd;
        end
        done0_d = ~win_q;
        done1_d = win_q;
      end
      RESP: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;   // master 0 takes the first tie
      starve_q   <= 4'd0;
      win_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata0_q   <= 32'd0;
      rdata1_q   <= 32'd0;
      bus_addr_q <= 32'd0;
      bus_wd_q   <= 32'd0;
      bus_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      starve_q   <= starve_d;
      win_q      <= win_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      bus_addr_q <= bus_addr_d;
      bus_wd_q   <= bus_wd_d;
      bus_we_q   <= bus_we_d;
      busy_q     <= busy_d;
    end
  end

  assign arb.m0_gnt   = gnt0_q;
  assign arb.m1_gnt   = gnt1_q;
  assign arb.m0_done  = done0_q;
  assign arb.m1_done  = done1_q;
  assign arb.m0_rdata = rdata0_q;
  assign arb.m1_rdata = rdata1_q;
  assign arb.bus_addr = bus_addr_q;
  assign arb.bus_wd   = bus_wd_q;
  assign arb.bus_we   = bus_we_q;
  assign arb.busy     = busy_q;

endmodule

// File: tb/tb_dev_bus_arb.sv
// tb_dev_bus_arb
//   Drives random master traffic (ties, mid-transaction request drops and
//   address changes, read/write mix, asynchronous resets) into a round-robin
//   arbiter and a fixed-priority arbiter (STARVE_LIMIT = 2), one at a time.
//   A transaction-level model predicts each grant and pushes the expected
//   ACCESS and RESP observations into queues; a monitor pops them when the
//   DUT shows a grant or done.
module tb_dev_bus_arb;

  localparam int LIM = 2;

  typedef struct {
    int          cyc;
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  int   cyc = 0;

  logic        m_req [2];
  logic        m_we  [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  logic [31:0] bus_rd;

  logic        o_gnt  [2];
  logic        o_done [2];
  logic [31:0] o_rdata[2];
  logic [31:0] o_bus_addr, o_bus_wd;
  logic        o_bus_we, o_busy;

  int checks = 0;
  int failures = 0;

  txn_t        aq[$];
  txn_t        dq[$];
  int          free_at = 0;
  bit          last_w = 1'b1;
  int          starve = 0;
  logic [31:0] exp_rd[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dev_bus_arb_if if_rr ();
  dev_bus_arb_if if_fx ();

  assign if_rr.m0_req  = !sel && m_req[0];
  assign if_rr.m1_req  = !sel && m_req[1];
  assign if_rr.m0_we   = m_we[0];
  assign if_rr.m1_we   = m_we[1];
  assign if_rr.m0_addr = m_addr[0];
  assign if_rr.m1_addr = m_addr[1];
  assign if_rr.m0_wd   = m_wd[0];
  assign if_rr.m1_wd   = m_wd[1];
  assign if_rr.bus_rd  = bus_rd;
  assign if_fx.m0_req  = sel && m_req[0];
  assign if_fx.m1_req  = sel && m_req[1];
  assign if_fx.m0_we   = m_we[0];
  assign if_fx.m1_we   = m_we[1];
  assign if_fx.m0_addr = m_addr[0];
  assign if_fx.m1_addr = m_addr[1];
  assign if_fx.m0_wd   = m_wd[0];
  assign if_fx.m1_wd   = m_wd[1];
  assign if_fx.bus_rd  = bus_rd;

  assign o_gnt[0]   = sel ? if_fx.m0_gnt   : if_rr.m0_gnt;
  assign o_gnt[1]   = sel ? if_fx.m1_gnt   : if_rr.m1_gnt;
  assign o_done[0]  = sel ? if_fx.m0_done  : if_rr.m0_done;
  assign o_done[1]  = sel ? if_fx.m1_done  : if_rr.m1_done;
  assign o_rdata[0] = sel ? if_fx.m0_rdata : if_rr.m0_rdata;
  assign o_rdata[1] = sel ? if_fx.m1_rdata : if_rr.m1_rdata;
  assign o_bus_addr = sel ? if_fx.bus_addr : if_rr.bus_addr;
  assign o_bus_wd   = sel ? if_fx.bus_wd   : if_rr.bus_wd;
  assign o_bus_we   = sel ? if_fx.bus_we   : if_rr.bus_we;
  assign o_busy     = sel ? if_fx.busy     : if_rr.busy;

  dev_bus_arb #(.PRIO_FIXED(0), .STARVE_LIMIT(8)) dut_rr (
    .clk(clk), .reset(reset), .arb(if_rr.slave)
  );
  dev_bus_arb #(.PRIO_FIXED(1), .STARVE_LIMIT(LIM)) dut_fx (
    .clk(clk), .reset(reset), .arb(if_fx.slave)
  );

  function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s mode=%0d cycle=%0d actual=%h required=%h", name, sel, cyc, act, req);
    end
  endfunction

  // Device read data is a known function of the cycle it is presented in.
  function automatic logic [31:0] rd_of(int c);
    return 32'hCAFE0001 ^ (32'(c) * 32'h9E3779B9);
  endfunction

  task automatic check_zero(string name);
    logic [101:0] all_out;
    all_out = {o_gnt[0], o_gnt[1], o_done[0], o_done[1], o_bus_we, o_busy,
               o_bus_addr, o_bus_wd, o_rdata[0] | o_rdata[1]};
    chk(all_out == '0, name, all_out[31:0] | all_out[101:70], 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_zero("reset_outputs");
    aq.delete();
    dq.delete();
    last_w = 1'b1;
    starve = 0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  // Reference model: decides at each idle sampling point who is granted
  // and what the bus and the done cycle must look like.
  task automatic model_step(int c);
    txn_t t;
    bit   w;
    if (free_at <= c && (m_req[0] || m_req[1])) begin
      if (m_req[0] && m_req[1]) w = sel ? (starve == LIM) : !last_w;
      else                      w = m_req[1];
      last_w = w;
      if (sel) begin
        if (w) starve = 0;
        else if (m_req[1] && starve < LIM) starve++;
      end
      t.id    = w;
      t.we    = m_we[w];
      t.addr  = m_addr[w];
      t.wd    = m_wd[w];
      t.rdata = rd_of(c + 1);
      t.cyc   = c + 1;
      aq.push_back(t);
      t.cyc   = c + 2;
      dq.push_back(t);
      $display("txn mode=%0d grant_cycle=%0d master=%0d we=%0d addr=%h wd=%h", sel, c + 1, w, t.we, t.addr, t.wd);
      free_at = c + 3;
    end
  endtask

  // Monitor
  initial begin
    txn_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        chk(!(o_gnt[0] && o_gnt[1]), "gnt_onehot", {31'd0, o_gnt[1]}, 32'd0);
        if (o_done[0] || o_done[1]) begin
          chk(!(o_done[0] && o_done[1]), "done_onehot", {31'd0, o_done[1]}, 32'd0);
          if (dq.size() == 0) begin
            chk(1'b0, "unexpected_done", {31'd0, o_done[1]}, 32'd0);
          end else begin
            e = dq.pop_front();
            chk(e.cyc == cyc, "done_cycle", 32'(cyc), 32'(e.cyc));
            chk(o_done[e.id] && !o_done[!e.id], "done_id", {31'd0, o_done[1]}, {31'd0, e.id});
            chk(o_gnt[e.id] && o_busy, "gnt_busy_resp", {30'd0, o_gnt[e.id], o_busy}, 32'd3);
            chk(!o_bus_we && o_bus_addr == 0 && o_bus_wd == 0, "bus_quiet_resp", o_bus_addr, 32'd0);
            if (!e.we) exp_rd[e.id] = e.rdata;
          end
        end else if (o_gnt[0] || o_gnt[1]) begin
          if (aq.size() == 0) begin
            chk(1'b0, "unexpected_grant", {31'd0, o_gnt[1]}, 32'd0);
          end else begin
            e = aq.pop_front();
            chk(e.cyc == cyc, "access_cycle", 32'(cyc), 32'(e.cyc));
            chk(o_gnt[1] == e.id, "grant_id", {31'd0, o_gnt[1]}, {31'd0, e.id});
            chk(o_bus_addr == e.addr, "bus_addr", o_bus_addr, e.addr);
            chk(o_bus_wd == e.wd, "bus_wd", o_bus_wd, e.wd);
            chk(o_bus_we == e.we, "bus_we", {31'd0, o_bus_we}, {31'd0, e.we});
            chk(o_busy, "busy_access", {31'd0, o_busy}, 32'd1);
          end
        end else begin
          chk(!o_bus_we && o_bus_addr == 0 && o_bus_wd == 0, "bus_quiet_idle", o_bus_addr, 32'd0);
          chk(!o_busy, "busy_idle", {31'd0, o_busy}, 32'd0);
          if (aq.size() > 0) chk(aq[0].cyc > cyc, "missing_grant", 32'(cyc), 32'(aq[0].cyc));
          if (dq.size() > 0) chk(dq[0].cyc > cyc, "missing_done", 32'(cyc), 32'(dq[0].cyc));
        end
        chk(o_rdata[0] == exp_rd[0], "m0_rdata", o_rdata[0], exp_rd[0]);
        chk(o_rdata[1] == exp_rd[1], "m1_rdata", o_rdata[1], exp_rd[1]);
      end
    end
  end

  // Stimulus
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_req[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = 32'd0; m_wd[k] = 32'd0;
      exp_rd[k] = 32'd0;
    end
    bus_rd = 32'd0;
    #2;
    check_zero("reset_initial");
    for (int mode = 0; mode < 2; mode++) begin
      if (mode == 1) begin
        @(posedge clk);
        #3;
        sel = 1'b1;
        apply_reset();
      end
      for (int n = 0; n < 500; n++) begin
        @(negedge clk);
        if (reset) begin
          reset = 1'b0;
          free_at = cyc;
        end
        for (int k = 0; k < 2; k++) begin
          if (n < 24)       m_req[k] = 1'b1;
          else if (n < 480) m_req[k] = ($urandom_range(0, 3) != 0);
          else              m_req[k] = 1'b0;
          m_we[k]   = ($urandom_range(0, 2) == 0);
          m_addr[k] = $urandom;
          m_wd[k]   = $urandom;
        end
        bus_rd = rd_of(cyc);
        model_step(cyc);
        if (n > 30 && n < 470 && $urandom_range(0, 39) == 0) begin
          @(posedge clk);
          #3;
          apply_reset();
        end
      end
      chk(aq.size() == 0, "grants_outstanding", 32'(aq.size()), 32'd0);
      chk(dq.size() == 0, "dones_outstanding", 32'(dq.size()), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
